// File: rtl/dq_float_hist.sv
// Six-tap quantized-difference float history for the zero predictor.
// A scan serially presents taps 1..6 from a frozen snapshot; at most one push arriving during a scan is deferred.
module dq_float_hist #(
    parameter int          NTAPS   = 6,
    parameter logic [10:0] RST_FLT = 11'h020
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] DQ0,
    input  logic        push,
    input  logic        scan,
    output logic        busy,
    output logic        tap_valid,
    output logic [2:0]  tap_idx,
    output logic [10:0] tap_dq,
    output logic        scan_done,
    output logic [10:0] DQ1,
    output logic        ovf
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t      state, state_nxt;
    logic [10:0] h     [NTAPS];
    logic [10:0] h_nxt [NTAPS];
    logic [10:0] pend, pend_nxt;
    logic        pend_vld, pend_vld_nxt;
    logic        ovf_nxt, busy_nxt, tv_nxt, done_nxt;
    logic [2:0]  idx_nxt;
    logic [10:0] tdq_nxt;

    assign DQ1 = h[0];

    always_comb begin
        state_nxt    = state;
        h_nxt        = h;
        pend_nxt     = pend;
        pend_vld_nxt = pend_vld;
        ovf_nxt      = ovf;
        busy_nxt     = 1'b0;
        tv_nxt       = 1'b0;
        done_nxt     = 1'b0;
        idx_nxt      = 3'd0;
        tdq_nxt      = 11'd0;
        case (state)
            IDLE: begin
                if (push) begin
                    h_nxt[0] = DQ0;
                    for (int k = 1; k < NTAPS; k++) h_nxt[k] = h[k-1];
                end
                // Tap 1 comes from the post-push history so a same-edge push is visible.
                if (scan) begin
                    state_nxt = SCAN;
                    busy_nxt  = 1'b1;
                    tv_nxt    = 1'b1;
                    idx_nxt   = 3'd1;
                    tdq_nxt   = h_nxt[0];
                end
            end
            SCAN: begin
                if (tap_idx == 3'(NTAPS)) begin
                    state_nxt    = IDLE;
                    pend_vld_nxt = 1'b0;
                    // Deferred value is older than a push on this edge, so it lands one slot deeper.
                    if (pend_vld && push) begin
                        h_nxt[0] = DQ0;
                        h_nxt[1] = pend;
                        for (int k = 2; k < NTAPS; k++) h_nxt[k] = h[k-2];
                    end else if (pend_vld || push) begin
                        h_nxt[0] = push ? DQ0 : pend;
                        for (int k = 1; k < NTAPS; k++) h_nxt[k] = h[k-1];
                    end
                end else begin
                    if (push) begin
                        pend_nxt     = DQ0;
                        pend_vld_nxt = 1'b1;
                        if (pend_vld) ovf_nxt = 1'b1;
                    end
                    busy_nxt = 1'b1;
                    tv_nxt   = 1'b1;
                    idx_nxt  = tap_idx + 3'd1;
                    tdq_nxt  = h[tap_idx];
                    done_nxt = (idx_nxt == 3'(NTAPS));
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            for (int k = 0; k < NTAPS; k++) h[k] <= RST_FLT;
            pend      <= 11'd0;
            pend_vld  <= 1'b0;
            ovf       <= 1'b0;
            busy      <= 1'b0;
            tap_valid <= 1'b0;
            scan_done <= 1'b0;
            tap_idx   <= 3'd0;
            tap_dq    <= 11'd0;
        end else begin
            state     <= state_nxt;
            h         <= h_nxt;
            pend      <= pend_nxt;
            pend_vld  <= pend_vld_nxt;
            ovf       <= ovf_nxt;
            busy      <= busy_nxt;
            tap_valid <= tv_nxt;
            scan_done <= done_nxt;
            tap_idx   <= idx_nxt;
            tap_dq    <= tdq_nxt;
        end
    end

endmodule

// File: tb/tb_dq_float_hist.sv
// Directed bench for dq_float_hist: hand-computed tap sequences, deferred pushes, overflow and async reset.
module tb_dq_float_hist;

    typedef logic [10:0] v6_t [6];

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] DQ0 = 11'd0;
    logic        push = 1'b0;
    logic        scan = 1'b0;
    logic        busy, tap_valid, scan_done, ovf;
    logic [2:0]  tap_idx;
    logic [10:0] tap_dq, DQ1;

    int nvec = 0;
    int nerr = 0;

    dq_float_hist dut (
        .clk(clk), .reset(reset), .DQ0(DQ0), .push(push), .scan(scan),
        .busy(busy), .tap_valid(tap_valid), .tap_idx(tap_idx), .tap_dq(tap_dq),
        .scan_done(scan_done), .DQ1(DQ1), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive strobes into one rising edge, then leave the bench 1ns after that edge.
    task automatic tick(input logic p, input logic s, input logic [10:0] d);
        push = p; scan = s; DQ0 = d;
        @(posedge clk);
        #1;
        push = 1'b0; scan = 1'b0; DQ0 = 11'd0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".tap_valid"}, 32'(tap_valid), 32'd0);
        chk({tag, ".busy"},      32'(busy),      32'd0);
        chk({tag, ".tap_idx"},   32'(tap_idx),   32'd0);
        chk({tag, ".tap_dq"},    32'(tap_dq),    32'd0);
        chk({tag, ".scan_done"}, 32'(scan_done), 32'd0);
    endtask

    // Scan at edge t (optionally with a push), then after tap k (edge t+k) apply pushes/scan as listed.
    task automatic do_scan(input string tag, input logic sp, input logic [10:0] sd, input v6_t e,
                           input int pk1, input logic [10:0] pv1, input int pk2, input logic [10:0] pv2,
                           input int sk, input logic ovf0, input int ovf_from);
        tick(sp, 1'b1, sd);
        for (int k = 1; k <= 6; k++) begin
            chk($sformatf("%s.valid%0d", tag, k), 32'(tap_valid), 32'd1);
            chk($sformatf("%s.busy%0d", tag, k),  32'(busy),      32'd1);
            chk($sformatf("%s.idx%0d", tag, k),   32'(tap_idx),   32'(k));
            chk($sformatf("%s.dq%0d", tag, k),    32'(tap_dq),    32'(e[k-1]));
            chk($sformatf("%s.done%0d", tag, k),  32'(scan_done), (k == 6) ? 32'd1 : 32'd0);
            chk($sformatf("%s.ovf%0d", tag, k),   32'(ovf),       (k >= ovf_from) ? 32'd1 : 32'(ovf0));
            tick((k == pk1) || (k == pk2), k == sk, (k == pk1) ? pv1 : pv2);
        end
        chk_idle({tag, ".end"});
    endtask

    initial begin
        #12;
        chk_idle("rst");
        chk("rst.ovf", 32'(ovf), 32'd0);
        chk("rst.DQ1", 32'(DQ1), 32'h020);
        @(posedge clk); #1; reset = 1'b0;

        do_scan("s0", 1'b0, 11'd0, '{11'h020, 11'h020, 11'h020, 11'h020, 11'h020, 11'h020},
                0, 11'd0, 0, 11'd0, 0, 1'b0, 7);
        chk("s0.DQ1", 32'(DQ1), 32'h020);

        tick(1'b1, 1'b0, 11'h401);
        tick(1'b1, 1'b0, 11'h0A5);
        tick(1'b1, 1'b0, 11'h7FF);
        chk("push3.DQ1", 32'(DQ1), 32'h7FF);
        do_scan("s1", 1'b0, 11'd0, '{11'h7FF, 11'h0A5, 11'h401, 11'h020, 11'h020, 11'h020},
                0, 11'd0, 0, 11'd0, 0, 1'b0, 7);

        // Push at t+3 is deferred until the edge leaving the scan.
        do_scan("s2", 1'b0, 11'd0, '{11'h7FF, 11'h0A5, 11'h401, 11'h020, 11'h020, 11'h020},
                3, 11'h155, 0, 11'd0, 0, 1'b0, 7);
        chk("s2.DQ1", 32'(DQ1), 32'h155);
        chk("s2.ovf", 32'(ovf), 32'd0);

        do_scan("s3", 1'b0, 11'd0, '{11'h155, 11'h7FF, 11'h0A5, 11'h401, 11'h020, 11'h020},
                2, 11'h111, 4, 11'h222, 0, 1'b0, 5);
        chk("s3.DQ1", 32'(DQ1), 32'h222);
        chk("s3.ovf", 32'(ovf), 32'd1);

        // Same-edge push and scan; 11'h111 must be gone from the history.
        do_scan("s4", 1'b1, 11'h333, '{11'h333, 11'h222, 11'h155, 11'h7FF, 11'h0A5, 11'h401},
                0, 11'd0, 0, 11'd0, 0, 1'b1, 7);

        // Pending plus push on the exit edge gives a double shift; scan mid-scan is ignored.
        do_scan("s5", 1'b0, 11'd0, '{11'h333, 11'h222, 11'h155, 11'h7FF, 11'h0A5, 11'h401},
                3, 11'h444, 6, 11'h555, 2, 1'b1, 7);
        chk("s5.DQ1", 32'(DQ1), 32'h555);
        chk("s5.ovf", 32'(ovf), 32'd1);
        do_scan("s6", 1'b0, 11'd0, '{11'h555, 11'h444, 11'h333, 11'h222, 11'h155, 11'h7FF},
                0, 11'd0, 0, 11'd0, 0, 1'b1, 7);

        // Reset in the middle of cycle t+3 with a deferred push outstanding.
        tick(1'b0, 1'b1, 11'd0);
        chk("r.valid1", 32'(tap_valid), 32'd1);
        tick(1'b1, 1'b0, 11'h666);
        tick(1'b0, 1'b0, 11'd0);
        chk("r.idx3", 32'(tap_idx), 32'd3);
        #2 reset = 1'b1;
        #1;
        chk_idle("r.async");
        chk("r.ovf", 32'(ovf), 32'd0);
        chk("r.DQ1", 32'(DQ1), 32'h020);
        @(posedge clk); #1; reset = 1'b0;
        do_scan("s7", 1'b0, 11'd0, '{11'h020, 11'h020, 11'h020, 11'h020, 11'h020, 11'h020},
                0, 11'd0, 0, 11'd0, 0, 1'b0, 7);
        chk("s7.DQ1", 32'(DQ1), 32'h020);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/dq_float_hist.md
DQ_FLOAT_HIST -- requirements
Module: dq_float_hist

Interface
REQ-001 Parameter NTAPS, default 6: number of stored quantized-difference floats, fixed at 6 for the G.721 zero predictor.
REQ-002 Parameter RST_FLT, default 11'h020: history reset value (sign 0, exp 0, mant 6'b100000).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 DQ0  in  11  float-format quantized difference {sign, exp[3:0], mant[5:0]} from the float-conversion stage.
REQ-006 push  in  1  one-cycle strobe: insert DQ0 as the newest history entry.
REQ-007 scan  in  1  one-cycle strobe: start a serial read of all taps for the multiplier stage.
REQ-008 busy  out  1  high while a scan is in progress.
REQ-009 tap_valid  out  1  tap_idx/tap_dq are valid this cycle.
REQ-010 tap_idx  out  3  tap number 1..6.
REQ-011 tap_dq  out  11  float value of tap tap_idx.
REQ-012 scan_done  out  1  one-cycle pulse coincident with the last tap.
REQ-013 DQ1  out  11  newest history entry H1, always driven.
REQ-014 ovf  out  1  sticky flag: a deferred push was overwritten.

Function
REQ-015 History registers H1..H6 (11 bits each) and all outputs SHALL be registered.
REQ-016 Reset values: H1..H6 = 11'h020; busy, tap_valid, scan_done, ovf = 0; tap_idx = 0; tap_dq = 0; pending buffer empty; FSM = IDLE.
REQ-017 FSM states: IDLE, SCAN. IDLE->SCAN on scan=1. SCAN->IDLE after tap 6 is presented.
REQ-018 Push in IDLE: at the sampling edge, H1<=DQ0, Hk<=H(k-1) for k=2..6, old H6 discarded.
REQ-019 Scan sampled at edge t: tap_valid=1 in cycles t+1..t+6 with tap_idx=1..6 and tap_dq=H1..H6 in order; busy=1 in the same cycles; scan_done=1 only in cycle t+6; IDLE from t+7.
REQ-020 Taps SHALL reflect the history snapshot at scan start; no shift is applied during SCAN.
REQ-021 Push during SCAN: DQ0 captured into a one-deep pending register; shift applied at the edge leaving SCAN, so DQ1 updates in cycle t+7.
REQ-022 Second push during the same SCAN: pending overwritten by the newer DQ0, ovf set to 1 and held until reset.
REQ-023 Push at the edge leaving SCAN while pending is full: pending shifted in first, then the new value, i.e. two shifts at one edge (H1=new, H2=pending); no ovf.
REQ-024 Push and scan at the same edge in IDLE: shift happens first; the scan reads the post-shift history (tap 1 = pushed DQ0).
REQ-025 Scan while in SCAN SHALL be ignored (no restart, no queueing).
REQ-026 When tap_valid=0: tap_idx=0 and tap_dq=0.
REQ-027 DQ0 is stored bit-exact; no arithmetic or format checking is performed.

Reset
REQ-028 Reset asserted at any time, including mid-scan, SHALL immediately force all state and outputs to the REQ-016 values; a scan in progress is abandoned and pending is discarded without setting ovf.
REQ-029 After reset release, the first rising edge SHALL process push/scan normally.

Verification
REQ-030 Reset then scan -> six tap_valid cycles, idx 1..6, every tap_dq=11'h020, scan_done in the sixth; DQ1=11'h020.
REQ-031 Push 11'h401, 11'h0A5, 11'h7FF in IDLE, then scan -> taps 1..3 = 11'h7FF, 11'h0A5, 11'h401; taps 4..6 = 11'h020.
REQ-032 Scan at edge t, push 11'h155 at t+3 -> taps unchanged snapshot, DQ1 becomes 11'h155 in cycle t+7, ovf=0.
REQ-033 Scan at t, push 11'h111 at t+2 and 11'h222 at t+4 -> ovf=1 from t+5; after scan H1=11'h222, 11'h111 lost.
REQ-034 Push 11'h333 and scan at the same edge -> tap 1 = 11'h333.
REQ-035 Reset asserted in cycle t+3 of a scan -> tap_valid, busy, scan_done, tap_dq fall to 0 asynchronously; next scan returns all 11'h020.
